// File: rtl/coeff_bank_pkg.sv
// Shared types and constants for the coefficient bank loader.
// Defaults: 25-bit signed mantissa, exponent -16 (value = mantissa * 2^-16).
package coeff_bank_pkg;

  localparam int COEFF_WIDTH  = 25;
  localparam int COEFF_EXP    = -16;
  localparam int COEFF_INIT_N = 4;

  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

  // {1.2, 3.4, 5.6, 7.8} at exponent -16
  localparam coeff_t COEFF_INIT [COEFF_INIT_N] = '{
    25'sd78643, 25'sd222822, 25'sd367002, 25'sd511181
  };

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  // Entries past the listed initial set come up as zero.
  function automatic coeff_t coeff_init(input int idx);
    coeff_t v;
    v = '0;
    if (idx < COEFF_INIT_N) v = COEFF_INIT[idx];
    return v;
  endfunction

endpackage

// File: rtl/coeff_bank_regfile.sv
// DEPTH x WIDTH coefficient register array: single-entry write, whole-bank
// load, registered read, async reset to the package initial set.
module coeff_bank_regfile #(
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 25,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        ld_all,
  input  logic [DEPTH-1:0][WIDTH-1:0] ld_data,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic [DEPTH-1:0][WIDTH-1:0] q
);
  import coeff_bank_pkg::*;

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(coeff_init(i));
      rd_data <= '0;
    end else begin
      // A whole-bank load wins over a single write in the same cycle.
      if (ld_all)  mem        <= ld_data;
      else if (we) mem[waddr] <= wdata;
      rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    end
  end

  assign q = mem;

endmodule

// File: rtl/coeff_bank_loader.sv
// Streaming coefficient loader with framing check and registered read port.
// Define COEFF_BANK_DOUBLE_BUF_EN for a shadow bank with atomic swap on commit.
module coeff_bank_loader #(
  parameter int COEFF_WIDTH = 25,
  parameter int COEFF_EXP   = -16,
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [COEFF_WIDTH-1:0] wr_data,
  input  logic                   wr_last,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [COEFF_WIDTH-1:0] rd_data,
  output logic                   commit,
  output logic                   err
);
  import coeff_bank_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wptr, wptr_nxt;
  logic                    err_nxt;
  logic                    wr_en;
  logic                    swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wptr  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      wptr  <= wptr_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    err_nxt   = err;
    wr_ready  = 1'b1;
    commit    = 1'b0;
    wr_en     = 1'b0;
    swap      = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wptr == LAST_PTR) begin
            wptr_nxt = '0;
            if (wr_last) begin
              state_nxt = COMMIT;
            end else begin
              state_nxt = IDLE;
              err_nxt   = 1'b1;
            end
          end else if (wr_last) begin
            // Set ended short: drop it and restart framing at entry 0.
            wptr_nxt  = '0;
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            wptr_nxt  = wptr + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      COMMIT: begin
        wr_ready  = 1'b0;
        commit    = 1'b1;
        swap      = 1'b1;
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [DEPTH-1:0][COEFF_WIDTH-1:0] active_q_unused;
  logic                              active_we;
  logic                              active_ld;
  logic [DEPTH-1:0][COEFF_WIDTH-1:0] active_ld_data;

`ifdef COEFF_BANK_DOUBLE_BUF_EN
  logic [DEPTH-1:0][COEFF_WIDTH-1:0] shadow_q;
  logic [COEFF_WIDTH-1:0]            shadow_rd_unused;

  coeff_bank_regfile #(.DEPTH(DEPTH), .WIDTH(COEFF_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (wptr),
    .wdata   (wr_data),
    .ld_all  (1'b0),
    .ld_data ('0),
    .rd_addr ('0),
    .rd_data (shadow_rd_unused),
    .q       (shadow_q)
  );

  assign active_we      = 1'b0;
  assign active_ld      = swap;
  assign active_ld_data = shadow_q;
`else
  assign active_we      = wr_en;
  assign active_ld      = 1'b0;
  assign active_ld_data = '0;
`endif

  coeff_bank_regfile #(.DEPTH(DEPTH), .WIDTH(COEFF_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_active (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (active_we),
    .waddr   (wptr),
    .wdata   (wr_data),
    .ld_all  (active_ld),
    .ld_data (active_ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .q       (active_q_unused)
  );

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Directed bench for coeff_bank_loader: table-driven read-back per phase plus
// hand-written load/abort/reset sequences. Tracks both buffering builds.
module tb_coeff_bank_loader;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_valid;
  logic               wr_ready;
  logic signed [24:0] wr_data;
  logic               wr_last;
  logic [1:0]         rd_addr;
  logic signed [24:0] rd_data;
  logic               commit;
  logic               err;

  int checks = 0;
  int fails  = 0;
  int commits = 0;

  coeff_bank_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .commit   (commit),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && commit === 1'b1) commits++;

`ifdef COEFF_BANK_DOUBLE_BUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef struct {
    int phase;
    int addr;
    int exp;
  } rvec_t;

  rvec_t tbl[$];

  task automatic add4(input int p, input int a0, input int a1, input int a2, input int a3);
    tbl.push_back('{p, 0, a0});
    tbl.push_back('{p, 1, a1});
    tbl.push_back('{p, 2, a2});
    tbl.push_back('{p, 3, a3});
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].phase == p) begin
        rd_addr = 2'(tbl[i].addr);
        step();
        check($sformatf("ph%0d_rd%0d", p, tbl[i].addr), int'(rd_data), tbl[i].exp);
      end
    end
  endtask

  task automatic beat(input int d, input bit last);
    wr_valid = 1'b1;
    wr_data  = 25'(d);
    wr_last  = last;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic load_set(input string nm, input int d0, input int d1, input int d2, input int d3);
    int c0;
    c0 = commits;
    beat(d0, 1'b0);
    beat(d1, 1'b0);
    beat(d2, 1'b0);
    beat(d3, 1'b1);
    check({nm, "_commit_ready"}, int'(wr_ready), 0);
    check({nm, "_commit_pulse"}, int'(commit), 1);
    step();
    check({nm, "_commit_cnt"}, commits - c0, 1);
    check({nm, "_ready_after"}, int'(wr_ready), 1);
    check({nm, "_err_clear"}, int'(err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int newat;

    add4(0, 78643, 222822, 367002, 511181);
    add4(1, 65536, -65536, 0, 131072);
    if (DBUF) add4(2, 65536, -65536, 0, 131072);
    else      add4(2, 111, 222, 0, 131072);
    add4(3, 1, 2, 3, 4);
    if (DBUF) add4(4, 1, 2, 3, 4);
    else      add4(4, 5, 6, 7, 8);
    add4(5, 9, 10, 11, 12);
    add4(6, 78643, 222822, 367002, 511181);
    add4(7, -1, -2, -3, -4);

    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; rd_addr = '0;
    step(); step();
    check("rst_ready", int'(wr_ready), 1);
    check("rst_err", int'(err), 0);
    check("rst_commit", int'(commit), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    run_phase(0);

    // Good load with addr 1 watched on every edge.
    rd_addr = 2'd1;
    step();
    check("atom_pre", int'(rd_data), 222822);
    newat = DBUF ? 6 : 3;
    c0 = commits;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data  = 25'(k == 0 ? 65536 : k == 1 ? -65536 : k == 2 ? 0 : 131072);
      wr_last  = (k == 3);
      check($sformatf("load_ready_b%0d", k + 1), int'(wr_ready), 1);
      step();
      check($sformatf("atom_e%0d", k + 1), int'(rd_data), (k + 1 >= newat) ? -65536 : 222822);
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    check("good_commit_ready", int'(wr_ready), 0);
    check("good_commit_pulse", int'(commit), 1);
    step();
    check("atom_e5", int'(rd_data), (5 >= newat) ? -65536 : 222822);
    check("good_ready_after", int'(wr_ready), 1);
    check("good_commit_gone", int'(commit), 0);
    step();
    check("atom_e6", int'(rd_data), -65536);
    check("good_commit_cnt", commits - c0, 1);
    run_phase(1);

    // Early last on beat 2.
    c0 = commits;
    beat(111, 1'b0);
    beat(222, 1'b1);
    check("early_err", int'(err), 1);
    check("early_ready", int'(wr_ready), 1);
    step();
    check("early_no_commit", commits - c0, 0);
    run_phase(2);
    check("early_err_sticky", int'(err), 1);
    load_set("recover", 1, 2, 3, 4);
    run_phase(3);

    // Missing last: four beats without wr_last.
    c0 = commits;
    beat(5, 1'b0); beat(6, 1'b0); beat(7, 1'b0); beat(8, 1'b0);
    check("miss_err", int'(err), 1);
    check("miss_ready", int'(wr_ready), 1);
    step();
    check("miss_no_commit", commits - c0, 0);
    run_phase(4);
    load_set("after_miss", 9, 10, 11, 12);
    run_phase(5);

    // Reset in the middle of a set.
    beat(100, 1'b0);
    beat(200, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_data", int'(rd_data), 0);
    check("midrst_ready", int'(wr_ready), 1);
    step();
    rst_n = 1'b1;
    check("midrst_err", int'(err), 0);
    run_phase(6);
    load_set("after_rst", -1, -2, -3, -4);
    run_phase(7);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/coeff_bank_loader.md
# coeff_bank_loader

Programmable fixed-point coefficient bank with a streaming valid/ready load port and a registered address-indexed read port. A control processor or testbench streams a full set of DEPTH coefficients into the block. Downstream datapath logic reads them by address in the same fixed-point format as the rest of the real-number datapath. With double buffering compiled in, a new set becomes visible atomically, so readers never see a half-updated table.

## Interface
- COEFF_WIDTH, 25: signed mantissa width of each coefficient.
- COEFF_EXP, -16: fixed-point exponent. Value = mantissa * 2^COEFF_EXP.
- DEPTH, 4: number of coefficients. Must be at least 2.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- wr_valid  in  1  load word valid.
- wr_ready  out  1  block can accept a load word.
- wr_data  in  COEFF_WIDTH  coefficient mantissa (signed).
- wr_last  in  1  marks the final word of a set.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  COEFF_WIDTH  coefficient at the registered rd_addr.
- commit  out  1  one-cycle pulse when a full set becomes active.
- err  out  1  sticky framing-error flag.

## Operation
- Active bank reset contents: COEFF_INIT from the package, which is {1.2, 3.4, 5.6, 7.8} at exp -16, i.e. {78643, 222822, 367002, 511181}.
- A beat is accepted when wr_valid && wr_ready. Words fill the shadow bank at an internal write pointer wptr, starting at 0 and incrementing by 1.
- FSM states:
  - IDLE: wr_ready=1. An accepted beat goes to LOAD.
  - LOAD: wr_ready=1. Beats continue to be accepted.
  - COMMIT: wr_ready=0 for exactly one cycle, then return to IDLE.
- Framing:
  - Beat DEPTH must carry wr_last=1. The block then enters COMMIT; in that cycle the shadow bank is copied to the active bank, commit=1, and err clears.
  - wr_last=1 on any beat before beat DEPTH is a framing error: abort the set.
  - wr_last=0 on beat DEPTH is a framing error: abort the set.
  - Abort: shadow discarded, active bank unchanged, err=1 (sticky), wptr=0, next state IDLE, no commit pulse.
- Index arithmetic: wptr counts 0..DEPTH-1 and never wraps into the next set. It is reset to 0 on commit and on abort.
- Read port: rd_data <= active[rd_addr] on every clock edge. Addresses at or above DEPTH (when DEPTH is not a power of 2) return 0.
- Reset asserted mid-load: the partial set is lost, active bank returns to COEFF_INIT, and the FSM returns to IDLE.

## Timing
- Reset values: wr_ready=1, rd_data=0, commit=0, err=0, state IDLE, wptr=0.
- Read latency: 1 cycle from rd_addr to rd_data.
- Commit latency: the edge accepting the last beat moves the FSM to COMMIT. The swap happens on the following edge.
  - A read sampled on that swap edge returns the old value.
  - A read sampled on the edge after the swap returns the new value.
- Minimum load time: DEPTH+1 cycles per set (DEPTH beats plus the COMMIT bubble).
- Simultaneous events:
  - A read during LOAD always returns the active (old) bank.
  - A beat presented during COMMIT is held by the source (wr_ready=0) and accepted in IDLE on the next cycle.

## Configuration
- COEFF_BANK_DOUBLE_BUF_EN defined: shadow bank plus atomic swap, exactly as described above.
- COEFF_BANK_DOUBLE_BUF_EN undefined:
  - No shadow bank; each accepted beat writes active[wptr] directly, so it is readable on the next read cycle.
  - COMMIT still pulses commit, but performs no copy.
  - An abort leaves partially written entries in place. err behaves the same.

## Structure
- Package coeff_bank_pkg holds:
  - COEFF_WIDTH and COEFF_EXP defaults.
  - COEFF_INIT array constant.
  - coeff_t typedef (logic signed [COEFF_WIDTH-1:0]).
  - State enum typedef {IDLE, LOAD, COMMIT}.
- One sub-module, coeff_bank_regfile: DEPTH x COEFF_WIDTH register array with async reset to COEFF_INIT, one write port, and a registered read port. It is instantiated as the active bank, and also as the shadow bank when double buffering is enabled.

## Test plan
- Reset: deassert rst_n, then read addr 0..3 -> 78643, 222822, 367002, 511181. err=0, wr_ready=1.
- Good load: stream {65536, -65536, 0, 131072} with wr_last on beat 4 -> commit high for exactly 1 cycle; reads of addr 0..3 return the new values; wr_ready low only in the COMMIT cycle.
- Atomicity (double buffering enabled): read addr 1 continuously during the load -> 222822 until the first read sampled after the swap edge, then -65536, with no intermediate value.
- Early last: wr_last on beat 2 -> err=1, no commit, addr 0..3 still return the previous set. The next good load clears err.
- Missing last: 4 beats with wr_last=0 -> err=1, no commit. A fifth beat starts a new set at wptr=0.
- Reset mid-load after 2 beats -> reads return COEFF_INIT, state IDLE. A following full load commits normally.
